convolution_controller: RTL and testbench

//  Sequences convolution_datapath over one frame of packed 4-pixel words.

---
 rtl/convolution_controller.sv | 79 +++++++
 tb/tb_convolution_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/convolution_controller.sv
// convolution_controller: steps the convolution datapath over one frame, hiding priming, flushing and tagging outputs
module convolution_controller #(
  parameter int WORDS_PER_ROW = 128,
  parameter int ROWS          = 480,
  parameter int ADDR_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              dp_clk_en,
  output logic [31:0]       dp_input_data,
  input  logic [31:0]       dp_output_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last
);
  localparam int TOTAL = ROWS * WORDS_PER_ROW;
  localparam int PRIME = 2 * WORDS_PER_ROW + 2;
  localparam int STEPS = TOTAL + 2;
  localparam int OUTS  = STEPS - PRIME;
  localparam int SW    = $clog2(STEPS + 1);
  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DRAIN} state_t;
  state_t r_state, w_next;
  logic [SW-1:0] r_step;
  logic [ADDR_W-1:0] r_addr;
  logic r_out_valid, r_frame_done;
  logic w_adv, w_accept, w_last, w_start;
  assign w_adv         = !r_out_valid || out_ready;
  assign w_accept      = r_out_valid && out_ready;
  assign w_last        = r_out_valid && (r_addr == ADDR_W'(OUTS - 1));
  assign w_start       = (r_state == IDLE) && start;
  assign in_ready      = (r_state == STREAM) && w_adv;
  assign dp_clk_en     = (in_ready && in_valid) || ((r_state == FLUSH) && w_adv);
  assign dp_input_data = (r_state == STREAM) ? in_data : 32'h0;
  assign busy          = r_state != IDLE;
  assign frame_done    = r_frame_done;
  assign out_valid     = r_out_valid;
  assign out_data      = dp_output_data;
  assign out_addr      = r_addr;
  assign out_last      = w_last;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = start ? STREAM : IDLE;
      STREAM:  w_next = (dp_clk_en && r_step == SW'(TOTAL - 1)) ? FLUSH : STREAM;
      FLUSH:   w_next = (dp_clk_en && r_step == SW'(STEPS - 1)) ? DRAIN : FLUSH;
      DRAIN:   w_next = (w_accept && w_last) ? IDLE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_step       <= '0;
      r_addr       <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_frame_done <= (r_state == DRAIN) && w_accept && w_last;
      // a step past priming presents a new word; otherwise an accept retires the held one
      r_out_valid  <= (dp_clk_en && r_step >= SW'(PRIME)) || (r_out_valid && !out_ready);
      if (w_start) begin
        r_step <= '0;
        r_addr <= '0;
      end else begin
        if (dp_clk_en) r_step <= r_step + SW'(1);
        if (w_accept) r_addr <= w_last ? '0 : r_addr + ADDR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_convolution_controller.sv
// tb_convolution_controller: directed frames against a vertical-gradient datapath stub with a scoreboard
module tb_convolution_controller;
  localparam int W = 4, R = 4, TOTAL = 16, PRIME = 10, STEPS = 18, OUTS = 8;
  logic clk, rst_n, start, busy, frame_done, in_valid, in_ready, dp_clk_en;
  logic out_valid, out_ready, out_last;
  logic [31:0] in_data, dp_input_data, dp_output_data, out_data;
  logic [15:0] out_addr;
  logic [31:0] sr [W*2];
  logic [31:0] frame [TOTAL];
  logic [31:0] q [$];
  logic [31:0] prev_data, exp_data;
  logic [15:0] prev_addr;
  logic stalled_prev = 1'b0;
  int n_tests = 0, n_fail = 0;
  int steps = 0, words = 0, accs = 0, dones = 0, s0 = 0, cyc = 0, first_cyc = 0, last_cyc = 0;

  convolution_controller #(.WORDS_PER_ROW(W), .ROWS(R), .ADDR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dp_clk_en(dp_clk_en), .dp_input_data(dp_input_data), .dp_output_data(dp_output_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // datapath stub: newest word minus the word two rows back
  always @(posedge clk) begin
    if (dp_clk_en) begin
      dp_output_data <= dp_input_data - sr[W*2-1];
      for (int i = W*2-1; i > 0; i--) sr[i] <= sr[i-1];
      sr[0] <= dp_input_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int i);
    return (i < TOTAL) ? frame[i] : 32'h0;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (in_ready) chk("step_follows_valid", 32'(dp_clk_en), 32'(in_valid));
    if (dp_clk_en) begin
      steps++;
      if (steps - s0 == 1) first_cyc = cyc;
      last_cyc = cyc;
      if (steps - s0 > TOTAL) chk("flush_zero", dp_input_data, 32'h0);
    end
    if (in_valid && in_ready) words++;
    if (stalled_prev && out_valid) begin
      chk("stall_data_hold", out_data, prev_data);
      chk("stall_addr_hold", 32'(out_addr), 32'(prev_addr));
    end
    if (out_valid && !out_ready) begin
      chk("stall_no_step", 32'(dp_clk_en), 32'h0);
      chk("stall_in_ready", 32'(in_ready), 32'h0);
    end
    stalled_prev = out_valid && !out_ready;
    prev_data = out_data;
    prev_addr = out_addr;
    if (!out_valid) chk("last_without_valid", 32'(out_last), 32'h0);
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(q.size() != 0), 32'h1);
      exp_data = (q.size() != 0) ? q.pop_front() : 32'hdeadbeef;
      chk("out_data", out_data, exp_data);
      chk("out_addr", 32'(out_addr), 32'(accs % OUTS));
      chk("out_last", 32'(out_last), 32'(accs % OUTS == OUTS - 1));
      accs++;
    end
    if (frame_done) dones++;
  end

  task automatic run_frame(input int mode, input bit abort);
    int w0, a0, d0, t, stall_n, idx;
    for (int i = 0; i < TOTAL; i++) frame[i] = $urandom;
    for (int k = 0; k < OUTS; k++) q.push_back(wd(PRIME + k) - wd(PRIME + k - 2*W));
    s0 = steps; w0 = words; a0 = accs; d0 = dones; t = 0; stall_n = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    while (dones == d0 && t < 300) begin
      if (abort && steps - s0 >= 7) break;
      idx = words - w0;
      in_valid = (mode == 2) ? (t % 2 == 0) : 1'b1;
      in_data = (idx < TOTAL) ? frame[idx] : 32'h0;
      out_ready = !(mode == 1 && accs == a0 && out_valid && stall_n < 5);
      if (!out_ready) stall_n++;
      start = (mode == 3 && t == 5);
      @(posedge clk); #1;
      t++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    if (abort) begin
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      q.delete();
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(dones - d0), 32'h0);
      chk("abort_idle", 32'(busy), 32'h0);
      chk("abort_out_valid", 32'(out_valid), 32'h0);
      return;
    end
    chk("frame_timeout", 32'(t < 300), 32'h1);
    chk("steps", 32'(steps - s0), 32'(STEPS));
    chk("words_in", 32'(words - w0), 32'(TOTAL));
    chk("outputs", 32'(accs - a0), 32'(OUTS));
    chk("busy_after", 32'(busy), 32'h0);
    chk("sb_drained", 32'(q.size()), 32'h0);
    if (mode == 0) chk("steps_back_to_back", 32'(last_cyc - first_cyc), 32'(STEPS - 1));
    if (mode == 1) chk("stall_cycles", 32'(stall_n), 32'h5);
    repeat (3) @(posedge clk);
    #1 chk("frame_done_once", 32'(dones - d0), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_dp_clk_en", 32'(dp_clk_en), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_addr", 32'(out_addr), 32'h0);
    chk("rst_frame_done", 32'(frame_done), 32'h0);
    @(posedge clk); #1 start = 1'b0; rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 chk("idle_after_rst", 32'(busy), 32'h0);
    run_frame(0, 1'b0);
    run_frame(1, 1'b0);
    run_frame(2, 1'b0);
    run_frame(3, 1'b0);
    run_frame(0, 1'b1);
    run_frame(0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
